// File: rtl/ssm_mux_tx.sv
// ssm_mux_tx: encoder-side substream multiplexer for the 4-substream VDC-M path.
// Four per-substream word FIFOs feed one serial output. A request-order queue
// records which substream the decoder model consumes next, so words leave in
// the exact order the decoder's demultiplexer will read them.
// Optional feature: define SSM_MUX_ERR_EN to compile in the sticky err_flags
// detectors; otherwise err_flags is tied to 0 and overflows drop silently.
module ssm_mux_tx #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned REQ_DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [3:0]          ssm_wr_en,
  input  logic [4*DATA_W-1:0] ssm_wr_data,
  output logic [3:0]          ssm_full,
  input  logic [3:0]          mux_req,
  output logic                req_rdy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_ssm,
  output logic [15:0]         out_word_cnt,
  output logic [1:0]          err_flags
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned QAW = $clog2(REQ_DEPTH);
  localparam logic [FAW:0] FIFO_FULL_CNT = (FAW+1)'(FIFO_DEPTH);
  localparam logic [QAW:0] REQ_DEPTH_CNT = (QAW+1)'(REQ_DEPTH);

  // Substream FIFO storage and pointers
  logic [DATA_W-1:0] fifo_mem [4][FIFO_DEPTH];
  logic [FAW-1:0]    f_wptr_q [4];
  logic [FAW-1:0]    f_rptr_q [4];
  logic [FAW:0]      f_cnt_q  [4];
  logic [3:0]        f_push;
  logic [3:0]        f_pop;

  // Request-order queue of 2-bit substream indices
  logic [1:0]        q_mem [REQ_DEPTH];
  logic [QAW-1:0]    q_wptr_q;
  logic [QAW-1:0]    q_rptr_q;
  logic [QAW:0]      q_cnt_q;
  logic [QAW:0]      q_free;
  logic [2:0]        enq_n;
  logic [1:0]        enq_sel [4];

  logic [1:0]        head;
  logic              load;

  // Status flags decoded from registered occupancy
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ssm_full[i] = (f_cnt_q[i] == FIFO_FULL_CNT);
    end
    q_free  = REQ_DEPTH_CNT - q_cnt_q;
    req_rdy = (q_free >= (QAW+1)'(4));
  end

  // Pack set request bits into consecutive queue slots, lowest substream first
  always_comb begin
    enq_n = 3'd0;
    for (int j = 0; j < 4; j++) begin
      enq_sel[j] = 2'd0;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_rdy && mux_req[i]) begin
        enq_sel[enq_n[1:0]] = 2'(i);
        enq_n = enq_n + 3'd1;
      end
    end
  end

  // Loader: strict head-of-line order, stall when the head's FIFO is empty
  always_comb begin
    head = q_mem[q_rptr_q];
    load = (q_cnt_q != '0) && (f_cnt_q[head] != '0) && (!out_valid || out_ready);
    for (int i = 0; i < 4; i++) begin
      f_push[i] = ssm_wr_en[i] && !ssm_full[i];
      f_pop[i]  = load && (head == 2'(i));
    end
  end

  // Storage arrays carry no reset; pointers and counts define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (f_push[i]) begin
        fifo_mem[i][f_wptr_q[i]] <= ssm_wr_data[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < enq_n) begin
        q_mem[q_wptr_q + QAW'(j)] <= enq_sel[j];
      end
    end
  end

  // FIFO pointer and occupancy update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        f_wptr_q[i] <= '0;
        f_rptr_q[i] <= '0;
        f_cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        f_wptr_q[i] <= f_wptr_q[i] + FAW'(f_push[i]);
        f_rptr_q[i] <= f_rptr_q[i] + FAW'(f_pop[i]);
        f_cnt_q[i]  <= f_cnt_q[i] + (FAW+1)'(f_push[i]) - (FAW+1)'(f_pop[i]);
      end
    end
  end

  // Request queue pointer and occupancy update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_wptr_q <= '0;
      q_rptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      q_wptr_q <= q_wptr_q + QAW'(enq_n);
      q_rptr_q <= q_rptr_q + QAW'(load);
      q_cnt_q  <= q_cnt_q + (QAW+1)'(enq_n) - (QAW+1)'(load);
    end
  end

  // Output register; data and source hold while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ssm   <= 2'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= fifo_mem[head][f_rptr_q[head]];
      out_ssm   <= head;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count of words accepted downstream, free-running wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_word_cnt <= 16'd0;
    end else if (out_valid && out_ready) begin
      out_word_cnt <= out_word_cnt + 16'd1;
    end
  end

`ifdef SSM_MUX_ERR_EN
  logic [1:0] err_q;

  // Sticky error detectors, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 2'b00;
    end else begin
      if (!req_rdy && (mux_req != 4'd0)) begin
        err_q[0] <= 1'b1;
      end
      if ((ssm_wr_en & ssm_full) != 4'd0) begin
        err_q[1] <= 1'b1;
      end
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 2'b00;
`endif

endmodule
